complex_divide: RTL and testbench

- Iterative complex divider: computes (i0 + j·q0) / (i1 + j·q1) as a signed fixed-point result with FRAC_BITS fractional bits.
- Used in the CSI extractor to normalise received pilot/LTF samples by known reference symbols. It is the inverse operation to the existing single-cycle complex multiply.
- Multi-cycle and non-pipelined, with a valid/ready accept handshake and a single-cycle result pulse.

---
 rtl/complex_divide.sv | 199 +++++++++++++++++++
 tb/tb_complex_divide.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_divide.sv
// Iterative complex divider: (i0 + j*q0) / (i1 + j*q1) as signed Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS.
// Both quotient components are produced by parallel restoring dividers sharing one denominator.
module complex_divide #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic signed [DATA_WIDTH-1:0] i0_in,
    input  logic signed [DATA_WIDTH-1:0] q0_in,
    input  logic signed [DATA_WIDTH-1:0] i1_in,
    input  logic signed [DATA_WIDTH-1:0] q1_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic signed [OUT_WIDTH-1:0]  i_out,
    output logic signed [OUT_WIDTH-1:0]  q_out,
    output logic                         valid_out,
    output logic                         sat_out,
    output logic                         div_zero_out
);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int NW    = PW + 1;
    localparam int QBITS = NW + FRAC_BITS;
    localparam int CW    = $clog2(QBITS + 1);
    localparam logic [QBITS-1:0] MAX_MAG = QBITS'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
    localparam logic [QBITS-1:0] MIN_MAG = MAX_MAG + QBITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;
    logic [CW-1:0] r_cnt;
    logic w_accept;
    logic w_last;

    logic signed [DATA_WIDTH-1:0] r_i0, r_q0, r_i1, r_q1;
    logic [QBITS-1:0] r_quo_i, r_quo_q;
    logic [PW-1:0]    r_rem_i, r_rem_q;
    logic [PW-1:0]    r_den;
    logic             r_neg_i, r_neg_q;

    logic signed [OUT_WIDTH-1:0] r_i_out, r_q_out;
    logic r_valid, r_sat, r_dz;

    logic signed [PW-1:0] w_i0x, w_q0x, w_i1x, w_q1x;
    logic signed [PW-1:0] w_p_ii, w_p_qq, w_p_qi, w_p_iq, w_p_i1sq, w_p_q1sq;
    logic signed [NW-1:0] w_num_i, w_num_q;
    logic [PW-1:0]        w_den;
    logic [PW:0]          w_step_i, w_step_q;
    logic [OUT_WIDTH:0]   w_cl_i, w_cl_q;

    function automatic logic [NW-1:0] f_abs(input logic signed [NW-1:0] v);
        return v[NW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // One restoring step: returns {next remainder, quotient bit}.
    function automatic logic [PW:0] f_div_step(input logic [PW-1:0] rem,
                                               input logic          bit_in,
                                               input logic [PW-1:0] den);
        logic [PW:0] sh;
        logic [PW:0] diff;
        sh   = {rem, bit_in};
        diff = sh - {1'b0, den};
        if (sh >= {1'b0, den}) begin
            return {diff[PW-1:0], 1'b1};
        end
        return {sh[PW-1:0], 1'b0};
    endfunction

    // Reapplies the sign to a magnitude quotient and clamps; returns {sat, value}.
    function automatic logic [OUT_WIDTH:0] f_clamp(input logic [QBITS-1:0] mag,
                                                   input logic             neg);
        logic [OUT_WIDTH-1:0] lo;
        lo = mag[OUT_WIDTH-1:0];
        if (!neg) begin
            if (mag > MAX_MAG) begin
                return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
            return {1'b0, lo};
        end
        if (mag > MIN_MAG) begin
            return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
        return {1'b0, -lo};
    endfunction

    assign w_accept = valid_in && ready_out;
    assign w_last   = (r_cnt == CW'(QBITS - 1));

    assign w_i0x = PW'(r_i0);
    assign w_q0x = PW'(r_q0);
    assign w_i1x = PW'(r_i1);
    assign w_q1x = PW'(r_q1);

    assign w_p_ii   = w_i0x * w_i1x;
    assign w_p_qq   = w_q0x * w_q1x;
    assign w_p_qi   = w_q0x * w_i1x;
    assign w_p_iq   = w_i0x * w_q1x;
    assign w_p_i1sq = w_i1x * w_i1x;
    assign w_p_q1sq = w_q1x * w_q1x;

    assign w_num_i = NW'(w_p_ii) + NW'(w_p_qq);
    assign w_num_q = NW'(w_p_qi) - NW'(w_p_iq);
    assign w_den   = $unsigned(w_p_i1sq) + $unsigned(w_p_q1sq);

    assign w_step_i = f_div_step(r_rem_i, r_quo_i[QBITS-1], r_den);
    assign w_step_q = f_div_step(r_rem_q, r_quo_q[QBITS-1], r_den);
    assign w_cl_i   = f_clamp(r_quo_i, r_neg_i);
    assign w_cl_q   = f_clamp(r_quo_q, r_neg_q);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MUL;
            S_MUL:   w_next = S_DIV;
            S_DIV:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_i_out <= '0;
            r_q_out <= '0;
            r_sat   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            if (r_state == S_MUL) begin
                r_cnt <= '0;
            end else if (r_state == S_DIV) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_DONE) begin
                r_valid <= 1'b1;
                // A zero divisor still runs the full iteration count; its quotient is discarded here.
                if (r_den == '0) begin
                    r_i_out <= '0;
                    r_q_out <= '0;
                    r_sat   <= 1'b0;
                    r_dz    <= 1'b1;
                end else begin
                    r_i_out <= w_cl_i[OUT_WIDTH-1:0];
                    r_q_out <= w_cl_q[OUT_WIDTH-1:0];
                    r_sat   <= w_cl_i[OUT_WIDTH] | w_cl_q[OUT_WIDTH];
                    r_dz    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    r_i0 <= i0_in;
                    r_q0 <= q0_in;
                    r_i1 <= i1_in;
                    r_q1 <= q1_in;
                end
            end
            S_MUL: begin
                r_quo_i <= {f_abs(w_num_i), {FRAC_BITS{1'b0}}};
                r_quo_q <= {f_abs(w_num_q), {FRAC_BITS{1'b0}}};
                r_neg_i <= w_num_i[NW-1];
                r_neg_q <= w_num_q[NW-1];
                r_rem_i <= '0;
                r_rem_q <= '0;
                r_den   <= w_den;
            end
            S_DIV: begin
                r_rem_i <= w_step_i[PW:1];
                r_rem_q <= w_step_q[PW:1];
                r_quo_i <= {r_quo_i[QBITS-2:0], w_step_i[0]};
                r_quo_q <= {r_quo_q[QBITS-2:0], w_step_q[0]};
            end
            default: ;
        endcase
    end

    assign ready_out    = (r_state == S_IDLE);
    assign i_out        = r_i_out;
    assign q_out        = r_q_out;
    assign valid_out    = r_valid;
    assign sat_out      = r_sat;
    assign div_zero_out = r_dz;

endmodule

// File: tb/tb_complex_divide.sv
// Self-checking bench for complex_divide: directed table, random vs. reference model,
// back-to-back handshake and mid-operation reset.
module tb_complex_divide;
    localparam int LAT = 49;
    localparam int GAP = 50;

    logic               clk_in = 1'b0;
    logic               rst_n_in;
    logic signed [15:0] i0_in, q0_in, i1_in, q1_in;
    logic               valid_in;
    logic               ready_out;
    logic signed [15:0] i_out, q_out;
    logic               valid_out, sat_out, div_zero_out;

    int total = 0;
    int bad   = 0;

    complex_divide dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .i0_in       (i0_in),
        .q0_in       (q0_in),
        .i1_in       (i1_in),
        .q1_in       (q1_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .i_out       (i_out),
        .q_out       (q_out),
        .valid_out   (valid_out),
        .sat_out     (sat_out),
        .div_zero_out(div_zero_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer quotient truncated toward zero, then clamped.
    function automatic longint q_comp(input longint n, input longint den, inout bit s);
        longint mag, v;
        mag = ((n < 0) ? -n : n) * 16384 / den;
        v   = (n < 0) ? -mag : mag;
        if (v > 32767) begin
            v = 32767;
            s = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            s = 1'b1;
        end
        return v;
    endfunction

    task automatic model(input int a, input int b, input int c, input int d,
                         output longint ei, output longint eq, output bit es, output bit edz);
        longint ni, nq, den;
        bit s;
        ni  = longint'(a) * c + longint'(b) * d;
        nq  = longint'(b) * c - longint'(a) * d;
        den = longint'(c) * c + longint'(d) * d;
        s   = 1'b0;
        edz = 1'b0;
        if (den == 0) begin
            ei  = 0;
            eq  = 0;
            edz = 1'b1;
        end else begin
            ei = q_comp(ni, den, s);
            eq = q_comp(nq, den, s);
        end
        es = s;
    endtask

    task automatic run_op(input int a, input int b, input int c, input int d,
                          output longint ri, output longint rq, output bit rs, output bit rdz,
                          output int lat, output int busy_bad);
        int w;
        w = 0;
        while (!ready_out && w < 200) begin
            @(negedge clk_in);
            w++;
        end
        check("ready_wait", (w < 200), 1);
        i0_in    = 16'(a);
        q0_in    = 16'(b);
        i1_in    = 16'(c);
        q1_in    = 16'(d);
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        i0_in    = 16'($urandom);
        q0_in    = 16'($urandom);
        i1_in    = 16'($urandom);
        q1_in    = 16'($urandom);
        lat      = 0;
        busy_bad = 0;
        while (lat < 200) begin
            @(posedge clk_in);
            lat++;
            @(negedge clk_in);
            if (valid_out) break;
            if (ready_out) busy_bad++;
        end
        ri  = i_out;
        rq  = q_out;
        rs  = sat_out;
        rdz = div_zero_out;
        check("ready_at_result", ready_out, 1);
        @(posedge clk_in);
        @(negedge clk_in);
        check("valid_pulse_width", valid_out, 0);
    endtask

    typedef struct {
        int     i0, q0, i1, q1;
        longint ei, eq;
        bit     es, edz;
    } vec_t;

    initial begin
        vec_t   tbl[8];
        longint ri, rq, ei, eq;
        bit     rs, rdz, es, edz;
        int     lat, busy_bad, a, b, c, d, nvalid, nres;
        longint qi[$], qq[$];
        bit     qs[$], qd[$];
        int     acc[$];

        tbl[0] = '{1000, 0, 1000, 0, 16384, 0, 1'b0, 1'b0};
        tbl[1] = '{0, 1000, 1000, 0, 0, 16384, 1'b0, 1'b0};
        tbl[2] = '{1, 0, 3, 0, 5461, 0, 1'b0, 1'b0};
        tbl[3] = '{-1, 0, 3, 0, -5461, 0, 1'b0, 1'b0};
        tbl[4] = '{3000, 4000, 0, 1000, 32767, -32768, 1'b1, 1'b0};
        tbl[5] = '{500, 7, 0, 0, 0, 0, 1'b0, 1'b1};
        tbl[6] = '{-32768, -32768, -32768, -32768, 16384, 0, 1'b0, 1'b0};
        tbl[7] = '{7, -3, 2, 5, -564, -23163, 1'b0, 1'b0};

        rst_n_in = 1'b0;
        valid_in = 1'b0;
        i0_in = '0; q0_in = '0; i1_in = '0; q1_in = '0;
        repeat (3) @(negedge clk_in);
        check("rst_ready", ready_out, 1);
        check("rst_i_out", i_out, 0);
        check("rst_q_out", q_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_sat", sat_out, 0);
        check("rst_dz", div_zero_out, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        for (int k = 0; k < 8; k++) begin
            run_op(tbl[k].i0, tbl[k].q0, tbl[k].i1, tbl[k].q1, ri, rq, rs, rdz, lat, busy_bad);
            check($sformatf("tbl%0d_i", k), ri, tbl[k].ei);
            check($sformatf("tbl%0d_q", k), rq, tbl[k].eq);
            check($sformatf("tbl%0d_sat", k), rs, tbl[k].es);
            check($sformatf("tbl%0d_dz", k), rdz, tbl[k].edz);
            check($sformatf("tbl%0d_latency", k), lat, LAT);
            check($sformatf("tbl%0d_ready_low", k), busy_bad, 0);
        end

        for (int k = 0; k < 40; k++) begin
            a = (k % 3 == 0) ? (int'($urandom_range(0, 2000)) - 1000) : int'(16'($urandom)) - 32768;
            b = int'(16'($urandom)) - 32768;
            if (k % 4 == 0) begin
                c = int'($urandom_range(0, 100)) - 50;
                d = int'($urandom_range(0, 100)) - 50;
            end else begin
                c = int'(16'($urandom)) - 32768;
                d = int'(16'($urandom)) - 32768;
            end
            model(a, b, c, d, ei, eq, es, edz);
            run_op(a, b, c, d, ri, rq, rs, rdz, lat, busy_bad);
            check($sformatf("rnd%0d_i", k), ri, ei);
            check($sformatf("rnd%0d_q", k), rq, eq);
            check($sformatf("rnd%0d_sat", k), rs, es);
            check($sformatf("rnd%0d_dz", k), rdz, edz);
        end

        nres = 0;
        for (int cyc = 0; cyc < 260; cyc++) begin
            @(negedge clk_in);
            if (valid_out) begin
                if (qi.size() == 0) begin
                    check("b2b_unexpected_result", 1, 0);
                end else begin
                    check("b2b_i", i_out, qi.pop_front());
                    check("b2b_q", q_out, qq.pop_front());
                    check("b2b_sat", sat_out, qs.pop_front());
                    check("b2b_dz", div_zero_out, qd.pop_front());
                    nres++;
                end
            end
            if (cyc < 210) begin
                a = int'(16'($urandom)) - 32768;
                b = int'(16'($urandom)) - 32768;
                c = int'(16'($urandom)) - 32768;
                d = int'(16'($urandom)) - 32768;
                i0_in = 16'(a); q0_in = 16'(b); i1_in = 16'(c); q1_in = 16'(d);
                valid_in = 1'b1;
                if (ready_out) begin
                    model(a, b, c, d, ei, eq, es, edz);
                    qi.push_back(ei); qq.push_back(eq); qs.push_back(es); qd.push_back(edz);
                    acc.push_back(cyc);
                end
            end else begin
                valid_in = 1'b0;
            end
        end
        check("b2b_results", nres, 5);
        check("b2b_accepts", acc.size(), 5);
        for (int k = 1; k < acc.size(); k++) begin
            check($sformatf("b2b_gap%0d", k), acc[k] - acc[k-1], GAP);
        end

        run_op(3000, 4000, 0, 1000, ri, rq, rs, rdz, lat, busy_bad);
        check("pre_rst_sat", rs, 1);
        i0_in = 16'(250); q0_in = '0; i1_in = 16'(1000); q1_in = '0;
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        repeat (20) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        check("midrst_ready", ready_out, 1);
        check("midrst_i_out", i_out, 0);
        check("midrst_q_out", q_out, 0);
        check("midrst_valid", valid_out, 0);
        check("midrst_sat", sat_out, 0);
        check("midrst_dz", div_zero_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_in);
            if (valid_out) nvalid++;
        end
        check("midrst_no_valid", nvalid, 0);
        run_op(250, 0, 1000, 0, ri, rq, rs, rdz, lat, busy_bad);
        check("post_rst_i", ri, 4096);
        check("post_rst_q", rq, 0);
        check("post_rst_sat", rs, 0);
        check("post_rst_latency", lat, LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
